// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding and constants for the CPU run controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RESET_CPU = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } ctrl_state_t;

  localparam int unsigned INSTR_ADDR_STEP = 4;

  // No halt opcode is matched; halting is purely PC- or budget-driven.
  localparam logic [31:0] HALT_OPCODE_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - program load word stream (valid/ready with last)
interface cpu_run_controller_if;

  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating RUN-cycle counter with clear and limit compare
module run_cycle_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             limit_hit
);

  logic [CYC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // One bit wider so a saturated count can never alias back onto the limit.
  assign limit_hit = (limit != '0) &&
                     (({1'b0, count_q} + (CYC_W+1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - load/reset/run/freeze sequencer for the CPU; optional CPU_RUN_CTRL_CHECKSUM_EN
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WORDS  = 64,
  parameter int ADDR_STEP  = INSTR_ADDR_STEP,
  parameter int RST_CYCLES = 2,
  parameter int CYC_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cpu_run_controller_if.slave  load,
  input  logic [31:0]          halt_pc,
  input  logic [CYC_W-1:0]     cycle_limit,
  input  logic [31:0]          pc_obs,
  input  logic [31:0]          alu_obs,
  output logic                 cpu_rst,
  output logic                 initialize,
  output logic [31:0]          init_data,
  output logic [31:0]          init_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CYC_W-1:0]     cycles_run,
  output logic [31:0]          result
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ctrl_state_t     state_q, state_d;
  logic [WC_W-1:0] wc_q, wc_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            last_q, last_d;
  logic            initialize_q, initialize_d;
  logic [31:0]     init_data_q, init_data_d;
  logic [31:0]     init_addr_q, init_addr_d;
  logic            err_q, err_d;
  logic [31:0]     result_q, result_d;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  logic [31:0]     csum_q, csum_d;
`endif

  logic accept;
  logic session_start;
  logic limit_hit;

  // last_q marks the write cycle of the final word, during which no more words are taken.
  assign load.load_ready = (state_q == LOAD) && !last_q;
  assign accept          = load.load_valid && load.load_ready;
  assign session_start   = start && ((state_q == IDLE) || (state_q == DONE));

  run_cycle_counter #(.CYC_W(CYC_W)) u_cycle_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (session_start),
    .en        (state_q == RUN),
    .limit     (cycle_limit),
    .count     (cycles_run),
    .limit_hit (limit_hit)
  );

  always_comb begin
    state_d      = state_q;
    wc_d         = wc_q;
    rc_d         = rc_q;
    last_d       = last_q;
    initialize_d = 1'b0;
    init_data_d  = init_data_q;
    init_addr_d  = init_addr_q;
    err_d        = err_q;
    result_d     = result_q;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          wc_d     = '0;
          last_d   = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (last_q) begin
          state_d = RESET_CPU;
          rc_d    = '0;
          last_d  = 1'b0;
        end else if (accept) begin
          if (wc_q == WC_W'(MAX_WORDS)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            initialize_d = 1'b1;
            init_data_d  = load.load_data;
            init_addr_d  = 32'(wc_q) * 32'(ADDR_STEP);
            wc_d         = wc_q + WC_W'(1);
            last_d       = load.load_last;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
            csum_d       = csum_q + load.load_data;
`endif
          end
        end
      end
      RESET_CPU: begin
        if (rc_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      RUN: begin
        if ((pc_obs == halt_pc) || limit_hit) begin
          result_d = alu_obs;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wc_q         <= '0;
      rc_q         <= '0;
      last_q       <= 1'b0;
      initialize_q <= 1'b0;
      init_data_q  <= '0;
      init_addr_q  <= '0;
      err_q        <= 1'b0;
      result_q     <= '0;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      rc_q         <= rc_d;
      last_q       <= last_d;
      initialize_q <= initialize_d;
      init_data_q  <= init_data_d;
      init_addr_q  <= init_addr_d;
      err_q        <= err_d;
      result_q     <= result_d;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign cpu_rst    = (state_q != RUN);
  assign initialize = initialize_q;
  assign init_data  = init_data_q;
  assign init_addr  = init_addr_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign result     = result_q;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller with a behavioural CPU stand-in
module tb_cpu_run_controller;

  localparam int MAX_WORDS  = 64;
  localparam int RST_CYCLES = 2;
  localparam int CYC_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      halt_pc = '0;
  logic [CYC_W-1:0] cycle_limit = '0;
  logic [31:0]      pc_obs, alu_obs;
  logic             cpu_rst, initialize, busy, done, err;
  logic [31:0]      init_data, init_addr, result;
  logic [CYC_W-1:0] cycles_run;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  always #5 clk = ~clk;

  cpu_run_controller_if lif ();

  cpu_run_controller #(
    .MAX_WORDS (MAX_WORDS),
    .ADDR_STEP (4),
    .RST_CYCLES(RST_CYCLES),
    .CYC_W     (CYC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load       (lif),
    .halt_pc    (halt_pc),
    .cycle_limit(cycle_limit),
    .pc_obs     (pc_obs),
    .alu_obs    (alu_obs),
    .cpu_rst    (cpu_rst),
    .initialize (initialize),
    .init_data  (init_data),
    .init_addr  (init_addr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycles_run (cycles_run),
    .result     (result)
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // CPU stand-in: run_k counts cycles out of reset; linear code steps PC by 4, loop code stays at 0.
  int   run_k = 0;
  logic prog_mode = 1'b0;
  logic loop_mode = 1'b0;

  function automatic logic [31:0] prog_alu(int k);
    case (k)
      0:       return 32'd5;
      1:       return 32'd3;
      2:       return 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cpu_rst) run_k <= 0;
    else         run_k <= run_k + 1;
  end

  always_comb begin
    pc_obs  = loop_mode ? 32'h0 : 32'(4 * (run_k + 1));
    alu_obs = prog_mode ? prog_alu(run_k) : (32'hC0DE_0000 + 32'(run_k));
  end

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          at;
  } wr_t;

  typedef struct {
    logic        err;
    logic [31:0] cycles;
    logic [31:0] result;
    logic [31:0] run;
    logic [31:0] sum;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];

  int          m_wc = 0;
  logic [31:0] m_sum = '0;
  bit          m_over = 0;
  logic [31:0] words[0:127];

  // Monitor
  int   run_cnt = 0;
  int   last_init = 0;
  logic prev_cpu_rst = 1'b1;
  logic prev_done = 1'b0;
  wr_t  mw;
  st_t  ms;

  always @(negedge clk) begin
    if (initialize) begin
      if (wr_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", init_addr, init_data);
      end else begin
        mw = wr_q.pop_front();
        chk("write_data", init_data, mw.data);
        chk("write_addr", init_addr, mw.addr);
        chk("write_cycle", 32'(cyc), 32'(mw.at));
      end
      last_init = cyc;
    end
    if (prev_cpu_rst && !cpu_rst) chk("reset_hold_cycles", 32'(cyc - last_init), 32'(RST_CYCLES + 1));
    if (!cpu_rst) run_cnt++;
    if (done && !prev_done) begin
      if (st_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no session end");
      end else begin
        ms = st_q.pop_front();
        chk("err", 32'(err), 32'(ms.err));
        chk("cycles_run", 32'(cycles_run), ms.cycles);
        chk("result", result, ms.result);
        chk("run_cycles_seen", 32'(run_cnt), ms.run);
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
        chk("checksum", checksum, ms.sum);
`endif
      end
      run_cnt = 0;
    end
    prev_cpu_rst = cpu_rst;
    prev_done    = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(logic [31:0] d, logic last);
    int n = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_last  = last;
    @(negedge clk);
    while (!lif.load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!lif.load_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got load_ready=0 expected 1 within 100 cycles");
    end else begin
      tick();
      if (m_wc == MAX_WORDS) begin
        m_over = 1;
      end else begin
        wr_q.push_back('{d, 32'(m_wc * 4), cyc});
        m_wc++;
        m_sum += d;
      end
    end
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start  = 1'b0;
    m_wc   = 0;
    m_sum  = '0;
    m_over = 0;
  endtask

  task automatic run_session(int n, bit last_final, logic [31:0] halt, logic [CYC_W-1:0] lim,
                             bit pm, bit lm, int gap);
    longint kh, k;
    int     g, w;
    st_t    s;
    halt_pc     = halt;
    cycle_limit = lim;
    prog_mode   = pm;
    loop_mode   = lm;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(-gap, 0));
      repeat (g) tick();
      send_word(words[i], last_final && (i == n - 1));
      if (m_over) break;
    end
    if (m_over) begin
      s = '{1'b1, 32'd0, 32'd0, 32'd0, m_sum};
    end else begin
      kh = 64'd1 << 40;
      if (lm) begin
        if (halt == 32'd0) kh = 1;
      end else if (halt[1:0] == 2'b00 && halt != 32'd0) begin
        kh = longint'(halt) / 4;
      end
      k = kh;
      if (lim != '0 && longint'(lim) < k) k = longint'(lim);
      s.err    = 1'b0;
      s.cycles = 32'(k);
      s.result = pm ? prog_alu(int'(k) - 1) : (32'hC0DE_0000 + 32'(k - 1));
      s.run    = 32'(k);
      s.sum    = m_sum;
    end
    st_q.push_back(s);
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got done=0 expected 1 within 3000 cycles");
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] h;
    logic [CYC_W-1:0] l;
    bit lm;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_last  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_initialize", 32'(initialize), 32'd0);
    chk("rst_init_data", init_data, 32'd0);
    chk("rst_init_addr", init_addr, 32'd0);
    chk("rst_load_ready", 32'(lif.load_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cycles_run", 32'(cycles_run), 32'd0);
    chk("rst_result", result, 32'd0);
    tick();
    rst = 1'b0;

    // load_valid while idle must be ignored
    lif.load_valid = 1'b1;
    lif.load_data  = 32'hBAD0_BAD0;
    repeat (3) tick();
    chk("idle_load_ready", 32'(lif.load_ready), 32'd0);
    lif.load_valid = 1'b0;
    tick();

    words[0] = 32'h2001_0005;
    words[1] = 32'h2002_0003;
    words[2] = 32'h0022_1820;
    run_session(3, 1, 32'h0000_000C, '0, 1, 0, 0);

    words[0] = 32'h0800_0000;
    run_session(1, 1, 32'hFFFF_FFFC, CYC_W'(10), 0, 1, 0);

    for (int i = 0; i <= MAX_WORDS; i++) words[i] = $urandom;
    run_session(MAX_WORDS + 1, 0, 32'h0, '0, 0, 0, 0);

    // abort mid-load, then restart from address 0
    pulse_start();
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_initialize", 32'(initialize), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_load_ready", 32'(lif.load_ready), 32'd0);
    chk("abort_pending_writes", 32'(wr_q.size()), 32'd0);
    tick();
    words[0] = 32'h3333_3333;
    words[1] = 32'h4444_4444;
    run_session(2, 1, 32'h0000_0008, '0, 0, 0, 0);

    words[0] = 32'd1;
    words[1] = 32'd2;
    run_session(2, 1, 32'h0000_0008, '0, 0, 0, 2);

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      h  = ($urandom_range(0, 1) == 1) ? 32'(4 * $urandom_range(1, 12)) : 32'hFFFF_FFF2;
      l  = CYC_W'($urandom_range(0, 20));
      lm = ($urandom_range(0, 1) == 1);
      if (l == '0 && (lm || h[1:0] != 2'b00)) l = CYC_W'($urandom_range(1, 20));
      run_session(int'($urandom_range(1, 8)), 1, h, l, 0, lm, -2);
    end

    chk("leftover_writes", 32'(wr_q.size()), 32'd0);
    chk("leftover_status", 32'(st_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
